// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg
// Shared definitions for the interval-timer tick scheduler:
//   - Avalon timer register addresses (16-bit register map)
//   - control register bit positions and the two control words we write
//   - FSM state encoding
package timer_sched_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;

  localparam int CTRL_ITO_BIT   = 0;
  localparam int CTRL_CONT_BIT  = 1;
  localparam int CTRL_START_BIT = 2;
  localparam int CTRL_STOP_BIT  = 3;

  localparam logic [15:0] CTRL_START_CONT_ITO = (16'd1 << CTRL_ITO_BIT)
                                              | (16'd1 << CTRL_CONT_BIT)
                                              | (16'd1 << CTRL_START_BIT);
  // STOP alone: ITO and CONT are deliberately written back to 0.
  localparam logic [15:0] CTRL_STOP = 16'd1 << CTRL_STOP_BIT;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_WR_PL,
    ST_WR_PH,
    ST_WR_CTRL,
    ST_RUN,
    ST_WR_STATUS,
    ST_UPDATE,
    ST_WR_STOP,
    ST_HALTED
  } sched_state_e;

endpackage

// File: rtl/timer_sched_div.sv
// timer_sched_div
// One tick channel: divides the serviced base tick by a programmable ratio.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   enable        channel enable; while low the phase counter is held at 0
//   div           divide ratio (0 is treated as 1)
//   advance       one-cycle strobe, one per serviced base tick
//   tick          registered one-cycle tick output
module timer_sched_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  input  logic             advance,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last;

  // Terminal count is d-1 with d = max(div, 1).
  always_comb begin
    last = (div == '0) ? '0 : div - DIV_W'(1);
  end

  // >= rather than == so that lowering div mid-phase cannot strand the
  // counter above the terminal value until it wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (!enable) begin
        cnt <= '0;
      end else if (advance) begin
        if (cnt >= last) begin
          cnt  <= '0;
          tick <= 1'b1;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/timer_tick_scheduler.sv
// timer_tick_scheduler
// Sole Avalon-MM master of an interval timer. Programs period/control after
// reset, clears the timeout status on each irq, and fans the resulting base
// tick out to NUM_CH divided tick channels.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   m_address/m_chipselect/
//   m_write_n/m_writedata        timer write port (no waitrequest)
//   timer_irq                    timer level interrupt
//   period_load, period_value    reprogram request and new period (counts-1)
//   halt                         stop request
//   ch_enable, ch_div            per-channel enable and divide ratio
//   ch_tick                      per-channel one-cycle tick
//   tick_count                   base ticks serviced since reset
//   running, busy                status flags
//
// state      | meaning
// -----------+-----------------------------------------------------------
// INIT       | reset hold; leads straight into the write sequence
// WR_PL      | write period_l = per[15:0]
// WR_PH      | write period_h = per[31:16]
// WR_CTRL    | write control = START|CONT|ITO
// RUN        | idle, dispatch halt > load > irq
// WR_STATUS  | write status to clear the timeout
// UPDATE     | count the base tick, advance channel dividers
// WR_STOP    | write control = STOP
// HALTED     | timer stopped, wait for a period load
module timer_tick_scheduler
  import timer_sched_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          DIV_W       = 16,
  parameter logic [31:0] PERIOD_INIT = 32'd49999
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic [2:0]              m_address,
  output logic                    m_chipselect,
  output logic                    m_write_n,
  output logic [15:0]             m_writedata,
  input  logic                    timer_irq,
  input  logic                    period_load,
  input  logic [31:0]             period_value,
  input  logic                    halt,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [NUM_CH*DIV_W-1:0] ch_div,
  output logic [NUM_CH-1:0]       ch_tick,
  output logic [31:0]             tick_count,
  output logic                    running,
  output logic                    busy
);

  sched_state_e state, state_nxt;
  logic [31:0]  per, per_nxt;
  logic         load_pend, halt_pend;
  logic         load_eff, halt_eff, load_take, in_idle;
  logic         wr_cs;
  logic [2:0]   wr_addr;
  logic [15:0]  wr_data;

  // per_nxt lets a load that triggers the reprogram in the same cycle put
  // its own value on the bus instead of the stale one.
  always_comb begin
    per_nxt  = period_load ? period_value : per;
    halt_eff = halt | halt_pend;
    load_eff = period_load | load_pend;
    in_idle  = (state == ST_RUN) || (state == ST_HALTED);

    state_nxt = state;
    case (state)
      ST_INIT:      state_nxt = ST_WR_PL;
      ST_WR_PL:     state_nxt = ST_WR_PH;
      ST_WR_PH:     state_nxt = ST_WR_CTRL;
      ST_WR_CTRL:   state_nxt = ST_RUN;
      ST_RUN: begin
        if (halt_eff)       state_nxt = ST_WR_STOP;
        else if (load_eff)  state_nxt = ST_WR_PL;
        else if (timer_irq) state_nxt = ST_WR_STATUS;
      end
      ST_WR_STATUS: state_nxt = ST_UPDATE;
      ST_UPDATE:    state_nxt = ST_RUN;
      ST_WR_STOP:   state_nxt = ST_HALTED;
      ST_HALTED: begin
        if (load_eff) state_nxt = ST_WR_PL;
      end
      default:      state_nxt = ST_INIT;
    endcase

    load_take = in_idle && (state_nxt == ST_WR_PL);

    // Bus values are decoded from the state being entered and registered,
    // so each write is visible in the same cycle as its state.
    wr_cs   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state_nxt)
      ST_WR_PL: begin
        wr_cs   = 1'b1;
        wr_addr = ADDR_PERIOD_L;
        wr_data = per_nxt[15:0];
      end
      ST_WR_PH: begin
        wr_cs   = 1'b1;
        wr_addr = ADDR_PERIOD_H;
        wr_data = per_nxt[31:16];
      end
      ST_WR_CTRL: begin
        wr_cs   = 1'b1;
        wr_addr = ADDR_CONTROL;
        wr_data = CTRL_START_CONT_ITO;
      end
      ST_WR_STATUS: begin
        wr_cs   = 1'b1;
        wr_addr = ADDR_STATUS;
        wr_data = 16'h0000;
      end
      ST_WR_STOP: begin
        wr_cs   = 1'b1;
        wr_addr = ADDR_CONTROL;
        wr_data = CTRL_STOP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_INIT;
      per          <= PERIOD_INIT;
      load_pend    <= 1'b0;
      halt_pend    <= 1'b0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= '0;
      m_writedata  <= '0;
      tick_count   <= '0;
      running      <= 1'b0;
      busy         <= 1'b1;
    end else begin
      state <= state_nxt;
      per   <= per_nxt;

      // A load seen while the FSM cannot act on it (or beaten by a halt in
      // RUN) is remembered; the latest period_value is already in per.
      if (load_take)        load_pend <= 1'b0;
      else if (period_load) load_pend <= 1'b1;

      // A halt in HALTED is meaningless and is dropped; in RUN it is acted
      // on directly, so the latch only covers the sequencing states.
      if (state == ST_RUN)                halt_pend <= 1'b0;
      else if (halt && !in_idle)          halt_pend <= 1'b1;

      m_chipselect <= wr_cs;
      m_write_n    <= ~wr_cs;
      m_address    <= wr_addr;
      m_writedata  <= wr_data;

      if (state == ST_UPDATE) tick_count <= tick_count + 32'd1;

      if (state == ST_WR_CTRL)      running <= 1'b1;
      else if (state == ST_WR_STOP) running <= 1'b0;

      busy <= !((state_nxt == ST_RUN) || (state_nxt == ST_HALTED));
    end
  end

  logic advance;
  assign advance = (state == ST_UPDATE);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_sched_div #(.DIV_W(DIV_W)) u_div (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (ch_enable[i]),
      .div     (ch_div[i*DIV_W +: DIV_W]),
      .advance (advance),
      .tick    (ch_tick[i])
    );
  end

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// tb_timer_tick_scheduler
// Scoreboard bench: expected timer writes and tick events are queued when
// stimulus is driven and compared by a negedge monitor as the DUT emits them.
module tb_timer_tick_scheduler;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 16;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [2:0]              m_address;
  logic                    m_chipselect;
  logic                    m_write_n;
  logic [15:0]             m_writedata;
  logic                    timer_irq;
  logic                    period_load;
  logic [31:0]             period_value;
  logic                    halt;
  logic [NUM_CH-1:0]       ch_enable;
  logic [NUM_CH*DIV_W-1:0] ch_div;
  logic [NUM_CH-1:0]       ch_tick;
  logic [31:0]             tick_count;
  logic                    running;
  logic                    busy;

  always #5 clk = ~clk;

  timer_tick_scheduler #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .PERIOD_INIT (32'd49999)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .timer_irq    (timer_irq),
    .period_load  (period_load),
    .period_value (period_value),
    .halt         (halt),
    .ch_enable    (ch_enable),
    .ch_div       (ch_div),
    .ch_tick      (ch_tick),
    .tick_count   (tick_count),
    .running      (running),
    .busy         (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct packed {
    logic [NUM_CH-1:0] tick;
    logic [31:0]       cnt;
  } tk_t;

  wr_t wr_q[$];
  tk_t tk_q[$];

  int unsigned m_cnt[NUM_CH];
  logic [31:0] m_tc;
  int          seen_ticks[NUM_CH];

  task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
  endtask

  // Reference divider model, advanced once per expected base tick.
  task automatic expect_service(output logic [NUM_CH-1:0] vec);
    tk_t t;
    vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      logic [DIV_W-1:0] dv;
      int unsigned d;
      dv = ch_div[i*DIV_W +: DIV_W];
      d  = (dv == '0) ? 1 : int'(dv);
      if (!ch_enable[i]) m_cnt[i] = 0;
      else if (m_cnt[i] == d - 1) begin
        m_cnt[i] = 0;
        vec[i]   = 1'b1;
      end else m_cnt[i] = m_cnt[i] + 1;
    end
    m_tc = m_tc + 32'd1;
    push_wr(3'd0, 16'h0000);
    t.tick = vec;
    t.cnt  = m_tc;
    tk_q.push_back(t);
  endtask

  task automatic step(input int k = 1);
    repeat (k) @(negedge clk);
  endtask

  task automatic check_reset_values();
    check_val("rst_cs",    32'(m_chipselect), 32'd0);
    check_val("rst_wr_n",  32'(m_write_n),    32'd1);
    check_val("rst_addr",  32'(m_address),    32'd0);
    check_val("rst_data",  32'(m_writedata),  32'd0);
    check_val("rst_tick",  32'(ch_tick),      32'd0);
    check_val("rst_tc",    tick_count,        32'd0);
    check_val("rst_run",   32'(running),      32'd0);
    check_val("rst_busy",  32'(busy),         32'd1);
  endtask

  // Release reset at a negedge (cycle 0) and check the startup sequence.
  task automatic release_and_start();
    push_wr(3'd2, 16'hC34F);
    push_wr(3'd3, 16'h0000);
    push_wr(3'd1, 16'h0007);
    reset_n = 1'b1;
    step();
    check_val("start_c1_cs",   32'(m_chipselect), 32'd1);
    check_val("start_c1_addr", 32'(m_address),    32'd2);
    step();
    check_val("start_c2_addr", 32'(m_address),    32'd3);
    step();
    check_val("start_c3_addr", 32'(m_address),    32'd1);
    check_val("start_c3_run",  32'(running),      32'd0);
    step();
    check_val("start_c4_run",  32'(running),      32'd1);
    check_val("start_c4_busy", 32'(busy),         32'd0);
    check_val("start_c4_cs",   32'(m_chipselect), 32'd0);
  endtask

  // Single-cycle irq pulse at cycle n (FSM in RUN); returns at n+4.
  task automatic service_irq();
    logic [NUM_CH-1:0] vec;
    expect_service(vec);
    timer_irq = 1'b1;
    step();
    timer_irq = 1'b0;
    check_val("svc_status_cs",   32'(m_chipselect), 32'd1);
    check_val("svc_status_addr", 32'(m_address),    32'd0);
    step();
    check_val("svc_tc_hold", tick_count, m_tc - 32'd1);
    step();
    check_val("svc_tc",   tick_count,   m_tc);
    check_val("svc_tick", 32'(ch_tick), 32'(vec));
    step();
    check_val("svc_tick_width", 32'(ch_tick), 32'd0);
  endtask

  // Monitor: compare every bus write and every tick event with the queues.
  initial begin
    wr_t w;
    tk_t t;
    logic [31:0] prev_tc;
    prev_tc = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_tc = '0;
      end else begin
        if (m_chipselect) begin
          if (wr_q.size() == 0) begin
            check_val("unexpected_write", 32'(wr_q.size()), 32'd1);
          end else begin
            w = wr_q.pop_front();
            check_val("wr_addr",   32'(m_address),   32'(w.addr));
            check_val("wr_data",   32'(m_writedata), 32'(w.data));
            check_val("wr_strobe", 32'(m_write_n),   32'd0);
          end
        end
        if (tick_count != prev_tc) begin
          if (tk_q.size() == 0) begin
            check_val("unexpected_tick", 32'(tk_q.size()), 32'd1);
          end else begin
            t = tk_q.pop_front();
            check_val("tk_vec", 32'(ch_tick), 32'(t.tick));
            check_val("tk_cnt", tick_count,   t.cnt);
          end
          for (int i = 0; i < NUM_CH; i++) seen_ticks[i] += int'(ch_tick[i]);
          prev_tc = tick_count;
        end else if (ch_tick != '0) begin
          check_val("spurious_tick", 32'(ch_tick), 32'd0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    timer_irq    = 1'b0;
    period_load  = 1'b0;
    period_value = '0;
    halt         = 1'b0;
    ch_enable    = 4'hF;
    ch_div       = {16'd0, 16'd3, 16'd2, 16'd1};
    m_tc         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i]      = 0;
      seen_ticks[i] = 0;
    end

    step(3);
    check_reset_values();
    release_and_start();

    // Six base ticks across divide ratios 1,2,3,0.
    repeat (6) service_irq();
    check_val("ch0_count", 32'(seen_ticks[0]), 32'd6);
    check_val("ch1_count", 32'(seen_ticks[1]), 32'd3);
    check_val("ch2_count", 32'(seen_ticks[2]), 32'd2);
    check_val("ch3_count", 32'(seen_ticks[3]), 32'd6);

    // Leave channel 1 mid-phase, disable it briefly: phase must restart.
    service_irq();
    ch_enable[1] = 1'b0;
    m_cnt[1]     = 0;
    step(2);
    ch_enable[1] = 1'b1;
    step();
    service_irq();
    service_irq();

    // Load during WR_STATUS, plus a timeout raised while reprogramming.
    begin
      logic [NUM_CH-1:0] vec;
      expect_service(vec);
      timer_irq = 1'b1;
      step();                                   // n+1 WR_STATUS
      timer_irq    = 1'b0;
      period_load  = 1'b1;
      period_value = 32'h0001_86A0;
      push_wr(3'd2, 16'h86A0);
      push_wr(3'd3, 16'h0001);
      push_wr(3'd1, 16'h0007);
      step();                                   // n+2 UPDATE
      period_load = 1'b0;
      step();                                   // n+3 tick visible
      check_val("ld_tick", 32'(ch_tick), 32'(vec));
      step();                                   // n+4 WR_PL
      check_val("ld_pl_addr", 32'(m_address), 32'd2);
      timer_irq = 1'b1;
      expect_service(vec);
      step(2);                                  // n+6 WR_CTRL
      check_val("ld_ctrl_data", 32'(m_writedata), 32'h7);
      step();                                   // n+7 RUN
      check_val("ld_run_cs", 32'(m_chipselect), 32'd0);
      step();                                   // n+8 WR_STATUS
      check_val("ld_irq_addr", 32'(m_address),    32'd0);
      check_val("ld_irq_cs",   32'(m_chipselect), 32'd1);
      timer_irq = 1'b0;
      step(3);
      check_val("ld_irq_tc", tick_count, m_tc);
    end

    // Halt and load in the same RUN cycle.
    halt         = 1'b1;
    period_load  = 1'b1;
    period_value = 32'h0000_0100;
    push_wr(3'd1, 16'h0008);
    push_wr(3'd2, 16'h0100);
    push_wr(3'd3, 16'h0000);
    push_wr(3'd1, 16'h0007);
    step();
    halt        = 1'b0;
    period_load = 1'b0;
    check_val("hl_stop_addr", 32'(m_address),   32'd1);
    check_val("hl_stop_data", 32'(m_writedata), 32'h8);
    step();
    check_val("hl_halt_run",  32'(running),      32'd0);
    check_val("hl_halt_cs",   32'(m_chipselect), 32'd0);
    check_val("hl_halt_busy", 32'(busy),         32'd0);
    step();
    check_val("hl_pl_addr", 32'(m_address), 32'd2);
    step(3);
    check_val("hl_restart_run", 32'(running), 32'd1);

    // Halt alone; irq while halted must be ignored.
    halt = 1'b1;
    push_wr(3'd1, 16'h0008);
    step();
    halt = 1'b0;
    step();
    timer_irq = 1'b1;
    step(3);
    timer_irq = 1'b0;
    check_val("halted_run",     32'(running), 32'd0);
    check_val("halted_no_tick", tick_count,   m_tc);
    step();
    period_load  = 1'b1;
    period_value = 32'h0000_C350;
    push_wr(3'd2, 16'hC350);
    push_wr(3'd3, 16'h0000);
    push_wr(3'd1, 16'h0007);
    step();
    period_load = 1'b0;
    step(3);
    check_val("resume_run", 32'(running), 32'd1);
    service_irq();

    // Reset asserted while WR_PH is on the bus.
    period_load  = 1'b1;
    period_value = 32'h1234_5678;
    push_wr(3'd2, 16'h5678);
    push_wr(3'd3, 16'h1234);
    step();
    period_load = 1'b0;
    step();
    #1 reset_n = 1'b0;
    #1;
    check_reset_values();
    check_val("rst_wr_q_empty", 32'(wr_q.size()), 32'd0);
    m_tc = '0;
    for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
    step(2);
    release_and_start();
    service_irq();
    service_irq();

    step(4);
    check_val("final_wr_q", 32'(wr_q.size()), 32'd0);
    check_val("final_tk_q", 32'(tk_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
